// File: rtl/fault_campaign_ctrl.sv
`timescale 1ns/1ps
// Purpose : hardware sweep of every single-stuck-at fault (site x polarity) of a
//           fault-injectable multiplier, comparing faulted vs golden products.
// Latency : 2 cycles per (fault, vector) pair (APPLY then COMPARE); 4*N_SITES*N_VEC
//           cycles per campaign without dropping.
// Backpressure: none; vector table and both multiplier instances answer combinationally.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle campaign request (honoured in IDLE/DONE only)
//   vec_idx             index into the external vector table
//   vec_a, vec_b        table operands for vec_idx (same cycle)
//   dut_a, dut_b        registered operands to both multiplier instances
//   fault_places        one-hot site select to the faulted instance
//   fault_control       stuck value per site to the faulted instance
//   dut_out, gold_out   faulted / golden products
//   busy, done          campaign running / campaign finished
//   det_sa0, det_sa1    per-site stuck-at-0 / stuck-at-1 detection flags
//   det_count           number of detected faults
//
// Optional build macro: FAULT_DROP_EN -- when defined, the remaining vectors of a
// fault are skipped as soon as that fault is detected.

module fault_campaign_ctrl #(
  parameter int N_SITES = 51,
  parameter int N_VEC   = 16,
  parameter int W       = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  output logic [$clog2(N_VEC)-1:0]           vec_idx,
  input  logic [W-1:0]                       vec_a,
  input  logic [W-1:0]                       vec_b,
  output logic [W-1:0]                       dut_a,
  output logic [W-1:0]                       dut_b,
  output logic [N_SITES-1:0]                 fault_places,
  output logic [N_SITES-1:0]                 fault_control,
  input  logic [2*W-1:0]                     dut_out,
  input  logic [2*W-1:0]                     gold_out,
  output logic                               busy,
  output logic                               done,
  output logic [N_SITES-1:0]                 det_sa0,
  output logic [N_SITES-1:0]                 det_sa1,
  output logic [$clog2(2*N_SITES+1)-1:0]     det_count
);

  localparam int VW = $clog2(N_VEC);
  localparam int SW = (N_SITES > 1) ? $clog2(N_SITES) : 1;
  localparam int CW = $clog2(2*N_SITES+1);

  localparam logic [N_SITES-1:0] ONE_SITE  = N_SITES'(1);
  localparam logic [VW-1:0]      LAST_VEC  = VW'(N_VEC-1);
  localparam logic [SW-1:0]      LAST_SITE = SW'(N_SITES-1);

  typedef enum logic [1:0] {IDLE, APPLY, COMPARE, DONE} state_t;

  state_t        state;
  logic [SW-1:0] site;
  logic          pol;

  logic               already_det;
  logic               new_det;
  logic               fault_end;
  logic               last_fault;
  logic [VW-1:0]      nxt_vec;
  logic [SW-1:0]      nxt_site;
  logic               nxt_pol;
  logic [N_SITES-1:0] nxt_places;
  logic [N_SITES-1:0] nxt_control;

  // A fault is counted once: only a mismatch on a still-undetected fault is new.
  assign already_det = pol ? det_sa1[site] : det_sa0[site];
  assign new_det     = (state == COMPARE) && (dut_out != gold_out) && !already_det;

`ifdef FAULT_DROP_EN
  // A fault detected on this vector needs no further vectors.
  assign fault_end = (vec_idx == LAST_VEC) || new_det;
`else
  assign fault_end = (vec_idx == LAST_VEC);
`endif

  assign last_fault = fault_end && pol && (site == LAST_SITE);

  // Next (site, pol, vec) with vector innermost, then polarity, then site.
  always_comb begin
    nxt_vec  = vec_idx + VW'(1);
    nxt_site = site;
    nxt_pol  = pol;
    if (fault_end) begin
      nxt_vec = '0;
      if (!pol) begin
        nxt_pol = 1'b1;
      end else begin
        nxt_pol = 1'b0;
        // Never step past the last site; the last fault goes to DONE instead.
        if (site != LAST_SITE) begin
          nxt_site = site + SW'(1);
        end
      end
    end
    nxt_places  = ONE_SITE << nxt_site;
    nxt_control = nxt_pol ? nxt_places : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      site          <= '0;
      pol           <= 1'b0;
      vec_idx       <= '0;
      dut_a         <= '0;
      dut_b         <= '0;
      fault_places  <= '0;
      fault_control <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      det_sa0       <= '0;
      det_sa1       <= '0;
      det_count     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            det_sa0       <= '0;
            det_sa1       <= '0;
            det_count     <= '0;
            site          <= '0;
            pol           <= 1'b0;
            vec_idx       <= '0;
            // Fault buses are set on entry to APPLY so they are stable for the
            // whole APPLY/COMPARE pair of this fault.
            fault_places  <= ONE_SITE;
            fault_control <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            state         <= APPLY;
          end
        end

        APPLY: begin
          dut_a <= vec_a;
          dut_b <= vec_b;
          state <= COMPARE;
        end

        COMPARE: begin
          if (new_det) begin
            if (pol) begin
              det_sa1[site] <= 1'b1;
            end else begin
              det_sa0[site] <= 1'b1;
            end
            det_count <= det_count + CW'(1);
          end
          if (last_fault) begin
            fault_places  <= '0;
            fault_control <= '0;
            busy          <= 1'b0;
            done          <= 1'b1;
            state         <= DONE;
          end else begin
            vec_idx       <= nxt_vec;
            site          <= nxt_site;
            pol           <= nxt_pol;
            fault_places  <= nxt_places;
            fault_control <= nxt_control;
            state         <= APPLY;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
`timescale 1ns/1ps
module tb_fault_campaign_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_s;
  logic start_b;
  int   mode;

`ifdef FAULT_DROP_EN
  localparam int EXP_SMALL_DET = 60;
  localparam int EXP_BIG       = 3264 - 51*30;
`else
  localparam int EXP_SMALL_DET = 64;
  localparam int EXP_BIG       = 3264;
`endif

  // ---------------- small instance: 4 sites, 4 vectors ----------------
  logic [1:0] vec_idx_s;
  logic [4:0] vec_a_s, vec_b_s, dut_a_s, dut_b_s;
  logic [3:0] places_s, control_s, det_sa0_s, det_sa1_s;
  logic [9:0] dut_out_s, gold_out_s;
  logic       busy_s, done_s;
  logic [3:0] det_count_s;

  // Table: A = vector index, B = 3. Stub faulted model mismatches only for
  // stuck-at-1 at site 2 on vectors 1 and 3 (mode 1).
  always_comb begin
    vec_a_s    = {3'b000, vec_idx_s};
    vec_b_s    = 5'd3;
    gold_out_s = 10'h000;
    dut_out_s  = 10'h000;
    if (mode == 1 && places_s[2] && control_s[2] && (dut_a_s == 5'd1 || dut_a_s == 5'd3))
      dut_out_s = 10'h001;
  end

  fault_campaign_ctrl #(.N_SITES(4), .N_VEC(4), .W(5)) u_small (
    .clk(clk), .rst(rst), .start(start_s),
    .vec_idx(vec_idx_s), .vec_a(vec_a_s), .vec_b(vec_b_s),
    .dut_a(dut_a_s), .dut_b(dut_b_s),
    .fault_places(places_s), .fault_control(control_s),
    .dut_out(dut_out_s), .gold_out(gold_out_s),
    .busy(busy_s), .done(done_s),
    .det_sa0(det_sa0_s), .det_sa1(det_sa1_s), .det_count(det_count_s)
  );

  // ---------------- default instance: 51 sites, 16 vectors ----------------
  logic [3:0]  vec_idx_b;
  logic [4:0]  vec_a_b, vec_b_b, dut_a_b, dut_b_b;
  logic [50:0] places_b, control_b, det_sa0_b, det_sa1_b;
  logic [9:0]  dut_out_b, gold_out_b;
  logic        busy_b, done_b;
  logic [6:0]  det_count_b;

  // Table A=B=31; faulted model corrupts the product whenever a stuck-at-1 is injected.
  always_comb begin
    vec_a_b    = 5'b11111;
    vec_b_b    = 5'b11111;
    gold_out_b = {5'b00000, dut_a_b} * {5'b00000, dut_b_b};
    dut_out_b  = (|control_b) ? ~gold_out_b : gold_out_b;
  end

  fault_campaign_ctrl u_big (
    .clk(clk), .rst(rst), .start(start_b),
    .vec_idx(vec_idx_b), .vec_a(vec_a_b), .vec_b(vec_b_b),
    .dut_a(dut_a_b), .dut_b(dut_b_b),
    .fault_places(places_b), .fault_control(control_b),
    .dut_out(dut_out_b), .gold_out(gold_out_b),
    .busy(busy_b), .done(done_b),
    .det_sa0(det_sa0_b), .det_sa1(det_sa1_b), .det_count(det_count_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts busy cycles of the small instance from the current negedge until done.
  task automatic count_busy_s(output int cyc);
    cyc = 0;
    for (int i = 0; i < 400; i++) begin
      if (done_s) break;
      if (busy_s) cyc++;
      @(negedge clk);
    end
    check("s_done_reached", {63'd0, done_s}, 64'd1);
  endtask

  task automatic pulse_start_s();
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
  endtask

  initial begin
    int cyc;
    rst     = 1'b1;
    start_s = 1'b0;
    start_b = 1'b0;
    mode    = 0;

    // 1. reset state
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy",     {63'd0, busy_s}, 64'd0);
    check("rst_done",     {63'd0, done_s}, 64'd0);
    check("rst_count",    {60'd0, det_count_s}, 64'd0);
    check("rst_places",   {60'd0, places_s}, 64'd0);
    check("rst_control",  {60'd0, control_s}, 64'd0);
    check("rst_dut_a",    {59'd0, dut_a_s}, 64'd0);
    check("rst_dut_b",    {59'd0, dut_b_s}, 64'd0);
    check("rst_big_busy", {63'd0, busy_b}, 64'd0);
    check("rst_big_cnt",  {57'd0, det_count_b}, 64'd0);

    // 2. no mismatches: first APPLY, first COMPARE, second APPLY, then full length
    mode = 0;
    pulse_start_s();
    check("t2_places0",  {60'd0, places_s}, 64'd1);
    check("t2_control0", {60'd0, control_s}, 64'd0);
    check("t2_vec_idx0", {62'd0, vec_idx_s}, 64'd0);
    check("t2_busy0",    {63'd0, busy_s}, 64'd1);
    @(negedge clk);
    check("t2_cmp_dut_b",  {59'd0, dut_b_s}, 64'd3);
    check("t2_cmp_places", {60'd0, places_s}, 64'd1);
    @(negedge clk);
    check("t2_vec_idx1", {62'd0, vec_idx_s}, 64'd1);
    count_busy_s(cyc);
    check("t2_busy_len", 64'(cyc + 2), 64'd64);
    check("t2_done",     {63'd0, done_s}, 64'd1);
    check("t2_count",    {60'd0, det_count_s}, 64'd0);
    check("t2_sa0",      {60'd0, det_sa0_s}, 64'd0);
    check("t2_sa1",      {60'd0, det_sa1_s}, 64'd0);
    check("t2_places_done", {60'd0, places_s}, 64'd0);

    // 3. mismatch only for sa1 at site 2 on vectors 1 and 3
    mode = 1;
    pulse_start_s();
    count_busy_s(cyc);
    check("t3_busy_len", 64'(cyc), 64'(EXP_SMALL_DET));
    check("t3_sa1",      {60'd0, det_sa1_s}, 64'b0100);
    check("t3_sa0",      {60'd0, det_sa0_s}, 64'd0);
    check("t3_count",    {60'd0, det_count_s}, 64'd1);

    // 5. start pulses at busy cycles 5 and 30 are ignored
    pulse_start_s();
    cyc = 0;
    for (int i = 0; i < 400; i++) begin
      if (done_s) break;
      if (busy_s) cyc++;
      start_s = (cyc == 5 || cyc == 30);
      @(negedge clk);
    end
    start_s = 1'b0;
    check("t5_done",     {63'd0, done_s}, 64'd1);
    check("t5_busy_len", 64'(cyc), 64'(EXP_SMALL_DET));
    check("t5_sa1",      {60'd0, det_sa1_s}, 64'b0100);
    check("t5_count",    {60'd0, det_count_s}, 64'd1);

    // 6. reset mid-campaign after the detection (detected at busy cycle 44)
    pulse_start_s();
    cyc = 0;
    for (int i = 0; i < 400; i++) begin
      if (busy_s) cyc++;
      if (cyc == 50 || done_s) break;
      @(negedge clk);
    end
    check("t6_pre_count", {60'd0, det_count_s}, 64'd1);
    check("t6_pre_busy",  {63'd0, busy_s}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_busy",    {63'd0, busy_s}, 64'd0);
    check("t6_done",    {63'd0, done_s}, 64'd0);
    check("t6_count",   {60'd0, det_count_s}, 64'd0);
    check("t6_sa1",     {60'd0, det_sa1_s}, 64'd0);
    check("t6_places",  {60'd0, places_s}, 64'd0);
    check("t6_dut_b",   {59'd0, dut_b_s}, 64'd0);
    check("t6_vec_idx", {62'd0, vec_idx_s}, 64'd0);
    mode = 0;
    pulse_start_s();
    check("t6_re_places",  {60'd0, places_s}, 64'd1);
    check("t6_re_control", {60'd0, control_s}, 64'd0);
    check("t6_re_vec_idx", {62'd0, vec_idx_s}, 64'd0);
    count_busy_s(cyc);
    check("t6_re_len",   64'(cyc), 64'd64);
    check("t6_re_count", {60'd0, det_count_s}, 64'd0);

    // 4. default size: every stuck-at-1 detected
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    cyc = 0;
    for (int i = 0; i < 5000; i++) begin
      if (done_b) break;
      if (busy_b) cyc++;
      @(negedge clk);
    end
    check("t4_done",     {63'd0, done_b}, 64'd1);
    check("t4_busy_len", 64'(cyc), 64'(EXP_BIG));
    check("t4_sa1",      {13'd0, det_sa1_b}, {13'd0, {51{1'b1}}});
    check("t4_sa0",      {13'd0, det_sa0_b}, 64'd0);
    check("t4_count",    {57'd0, det_count_b}, 64'd51);
    check("t4_places",   {13'd0, places_b}, 64'd0);
    check("t4_dut_a",    {59'd0, dut_a_b}, 64'd31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
